ascii_serial_tx: RTL

//  Downstream stage of the one-hot pattern coder: accepts 7-bit ASCII characters over a

---
 rtl/ascii_serial_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ascii_serial_tx.sv
// ascii_serial_tx
//   Buffers 7-bit ASCII characters in a small FIFO and sends each one on a
//   single pin as an asynchronous frame. The frame is a start bit (0), then
//   7 data bits LSB first, then an optional even-parity bit, then a stop
//   bit (1). Each bit is held for BIT_TICKS clock cycles.
//
// Handshake: a character transfers on a rising CLK edge where in_valid and
//   in_ready are both 1. in_ready depends only on the FIFO fill level and
//   never on in_valid. While in_valid is 0, ascii is ignored.
//
// Ports
//   CLK          in   1  clock; all state changes on posedge
//   RST_N        in   1  asynchronous active-low reset
//   ascii        in   7  character to send
//   in_valid     in   1  ascii holds a character
//   in_ready     out  1  FIFO has room (not full)
//   tx           out  1  serial line, idle high, driven from a flop
//   busy         out  1  a frame is in progress (FSM not in IDLE)
//   o_dbg_state  out  3  current FSM state, for observation only
module ascii_serial_tx #(
  parameter int BIT_TICKS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] ascii,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------
  // Character FIFO
  // ---------------------------------------------------------------
  logic [6:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_load;
  logic          w_empty;
  logic [6:0]    w_head;

  assign in_ready = (r_count != FULL_CNT);
  assign w_push   = in_valid & in_ready;
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];

  // Storage is not reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ascii;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [6:0]    r_shift;
  logic [6:0]    w_shift_nxt;
  logic          r_par;
  logic          w_par_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          w_wrap;

  assign w_wrap = (r_tick == TICK_LAST);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. w_load pops the FIFO head into the shifter; the
  // decision uses the registered count, so a character pushed into an
  // empty FIFO is only seen on the following edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
        end
      end
      S_START: begin
        if (w_wrap) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_wrap && (r_bit == 3'd6)) begin
          w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_wrap) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_wrap) begin
          if (!w_empty) begin
            w_state_nxt = S_START;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: tick counter, data-bit counter, shifter, parity.
  always_comb begin
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;

    // Tick stays at 0 in IDLE so a freshly loaded frame starts a full bit.
    if ((r_state == S_IDLE) || w_wrap) begin
      w_tick_nxt = '0;
    end else begin
      w_tick_nxt = r_tick + TW'(1);
    end

    if (r_state != S_DATA) begin
      w_bit_nxt = 3'd0;
    end else if (w_wrap) begin
      w_bit_nxt = r_bit + 3'd1;
    end

    if (w_load) begin
      w_shift_nxt = w_head;
      w_par_nxt   = ^w_head;
    end else if ((r_state == S_DATA) && w_wrap) begin
      w_shift_nxt = {1'b0, r_shift[6:1]};
    end
  end

  // Output logic. tx is registered: the line level for the coming cycle
  // is derived from the next state and latched on the same edge.
  always_comb begin
    busy        = (r_state != S_IDLE);
    o_dbg_state = r_state;
    case (w_state_nxt)
      S_IDLE:   w_tx_nxt = 1'b1;
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      S_STOP:   w_tx_nxt = 1'b1;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 7'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign tx = r_tx;

endmodule
